// File: rtl/instr_fetch_unit_if.sv
// Memory-side bus of the instruction fetch unit.
// master: fetch unit (issues read requests, consumes responses)
// slave : instruction memory
//   mem_req_valid / mem_req_ready : request handshake
//   mem_addr                      : request address
//   mem_rsp_valid / mem_rdata     : read response
//   mem_rsp_err                   : bus error, qualified by mem_rsp_valid
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic            mem_rsp_valid;
    logic [31:0]     mem_rdata;
    logic            mem_rsp_err;

    modport master (
        output mem_req_valid,
        output mem_addr,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rdata,
        input  mem_rsp_err
    );

    modport slave (
        input  mem_req_valid,
        input  mem_addr,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rdata,
        output mem_rsp_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the multicycle RV32I core. Holds PC, OldPC and the
// instruction register; fetches from a variable-latency memory.
// Ports:
//   clk, reset (async, active-low)
//   fetch_start : control-unit fetch trigger (honoured in IDLE only)
//   pcwrite     : commit pc_next into PC (honoured in IDLE only)
//   pc_next     : new PC value
//   mem         : memory bus (master side)
//   pc, oldpc, instr, opcode, funct3, func7_bit5 : architectural outputs
//   instr_valid : instr holds a freshly fetched instruction
//   busy        : fetch outstanding (REQ or WAIT)
//   fetch_fault : sticky fault (misaligned PC or bus error)
module instr_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_start,
    input  logic                 pcwrite,
    input  logic [XLEN-1:0]      pc_next,
    instr_fetch_unit_if.master   mem,
    output logic [XLEN-1:0]      pc,
    output logic [XLEN-1:0]      oldpc,
    output logic [31:0]          instr,
    output logic [6:0]           opcode,
    output logic [2:0]           funct3,
    output logic                 func7_bit5,
    output logic                 instr_valid,
    output logic                 busy,
    output logic                 fetch_fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] oldpc_q, oldpc_d;
    logic [31:0]     instr_q, instr_d;
    logic            ivalid_q, ivalid_d;
    logic [XLEN-1:0] fetch_pc;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            oldpc_q  <= '0;
            instr_q  <= NOP_INSTR;
            ivalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            oldpc_q  <= oldpc_d;
            instr_q  <= instr_d;
            ivalid_q <= ivalid_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        oldpc_d  = oldpc_q;
        instr_d  = instr_q;
        ivalid_d = ivalid_q;
        // A same-cycle pcwrite takes effect before the fetch, so the
        // alignment check must look at pc_next rather than pc_q.
        fetch_pc = pcwrite ? pc_next : pc_q;
        unique case (state_q)
            IDLE: begin
                if (pcwrite) begin
                    pc_d = pc_next;
                end
                if (fetch_start) begin
                    ivalid_d = 1'b0;
                    state_d  = (fetch_pc[1:0] != 2'b00) ? FAULT : REQ;
                end
            end
            REQ: begin
                if (mem.mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem.mem_rsp_valid) begin
                    if (mem.mem_rsp_err) begin
                        state_d = FAULT;
                    end else begin
                        instr_d  = mem.mem_rdata;
                        oldpc_d  = pc_q;
                        ivalid_d = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            FAULT: begin
                ivalid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: decoded from the state register so reset drops them at once
    always_comb begin
        mem.mem_req_valid = (state_q == REQ);
        mem.mem_addr      = pc_q;
        busy              = (state_q == REQ) || (state_q == WAIT);
        fetch_fault       = (state_q == FAULT);
        instr_valid       = ivalid_q && (state_q != FAULT);
        pc                = pc_q;
        oldpc             = oldpc_q;
        instr             = instr_q;
        opcode            = instr_q[6:0];
        funct3            = instr_q[14:12];
        func7_bit5        = instr_q[30];
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        fetch_start;
    logic        pcwrite;
    logic [31:0] pc_next;
    logic [31:0] pc;
    logic [31:0] oldpc;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        func7_bit5;
    logic        instr_valid;
    logic        busy;
    logic        fetch_fault;

    int n_checks;
    int n_errors;

    instr_fetch_unit_if #(.XLEN(32)) bus ();

    instr_fetch_unit #(
        .XLEN      (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_start (fetch_start),
        .pcwrite     (pcwrite),
        .pc_next     (pc_next),
        .mem         (bus),
        .pc          (pc),
        .oldpc       (oldpc),
        .instr       (instr),
        .opcode      (opcode),
        .funct3      (funct3),
        .func7_bit5  (func7_bit5),
        .instr_valid (instr_valid),
        .busy        (busy),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_start       = 1'b0;
        pcwrite           = 1'b0;
        pc_next           = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = '0;
        bus.mem_rsp_err   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #12;
        n_checks++; if (pc !== 32'h0) begin n_errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
        n_checks++; if (oldpc !== 32'h0) begin n_errors++; $display("FAIL reset_oldpc got %h exp %h", oldpc, 32'h0); end
        n_checks++; if (instr !== 32'h13) begin n_errors++; $display("FAIL reset_instr got %h exp %h", instr, 32'h13); end
        n_checks++; if ({instr_valid, bus.mem_req_valid, busy, fetch_fault} !== 4'b0000) begin
            n_errors++; $display("FAIL reset_flags got %b exp 0000", {instr_valid, bus.mem_req_valid, busy, fetch_fault});
        end
        @(posedge clk); #1;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_fetch();
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        // cycle 1: REQ
        n_checks++; if (bus.mem_req_valid !== 1'b1) begin n_errors++; $display("FAIL basic_req_valid got %b exp 1", bus.mem_req_valid); end
        n_checks++; if (bus.mem_addr !== 32'h0) begin n_errors++; $display("FAIL basic_addr got %h exp %h", bus.mem_addr, 32'h0); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy got %b exp 1", busy); end
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        // cycle 2: WAIT
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL basic_wait_req got %b exp 0", bus.mem_req_valid); end
        n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL basic_early_valid got %b exp 0", instr_valid); end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h0050_0093;
        tick();
        bus.mem_rsp_valid = 1'b0;
        // cycle 3: result visible
        n_checks++; if (instr_valid !== 1'b1) begin n_errors++; $display("FAIL basic_valid got %b exp 1", instr_valid); end
        n_checks++; if (instr !== 32'h0050_0093) begin n_errors++; $display("FAIL basic_instr got %h exp %h", instr, 32'h0050_0093); end
        n_checks++; if (opcode !== 7'h13) begin n_errors++; $display("FAIL basic_opcode got %h exp %h", opcode, 7'h13); end
        n_checks++; if (funct3 !== 3'd0) begin n_errors++; $display("FAIL basic_funct3 got %h exp 0", funct3); end
        n_checks++; if (oldpc !== 32'h0) begin n_errors++; $display("FAIL basic_oldpc got %h exp 0", oldpc); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_backpressure();
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        // cycles 1..3: REQ stalled; control pulses must be ignored
        for (int i = 1; i <= 3; i++) begin
            n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h0) begin
                n_errors++; $display("FAIL bp_req_hold c%0d got v=%b a=%h exp v=1 a=0", i, bus.mem_req_valid, bus.mem_addr);
            end
            if (i == 2) begin
                fetch_start = 1'b1;
                pcwrite     = 1'b1;
                pc_next     = 32'h100;
            end
            tick();
            fetch_start = 1'b0;
            pcwrite     = 1'b0;
        end
        // cycle 4: accepted
        n_checks++; if (pc !== 32'h0) begin n_errors++; $display("FAIL bp_pc_req got %h exp 0", pc); end
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        // cycle 5: WAIT, no response yet
        pcwrite = 1'b1;
        pc_next = 32'h200;
        tick();
        pcwrite = 1'b0;
        // cycle 6: response
        n_checks++; if (pc !== 32'h0) begin n_errors++; $display("FAIL bp_pc_wait got %h exp 0", pc); end
        n_checks++; if (instr_valid !== 1'b0 || busy !== 1'b1) begin
            n_errors++; $display("FAIL bp_wait_state got iv=%b busy=%b exp iv=0 busy=1", instr_valid, busy);
        end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h4000_0033;
        tick();
        bus.mem_rsp_valid = 1'b0;
        // cycle 7
        n_checks++; if (instr_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid c7 got %b exp 1", instr_valid); end
        n_checks++; if (opcode !== 7'h33 || func7_bit5 !== 1'b1) begin
            n_errors++; $display("FAIL bp_decode got op=%h f7=%b exp op=33 f7=1", opcode, func7_bit5);
        end
        // pcwrite after a fetch must not disturb instr/oldpc/instr_valid
        pcwrite = 1'b1;
        pc_next = 32'h40;
        tick();
        pcwrite = 1'b0;
        n_checks++; if (pc !== 32'h40) begin n_errors++; $display("FAIL pcwrite_pc got %h exp %h", pc, 32'h40); end
        n_checks++; if (instr !== 32'h4000_0033 || oldpc !== 32'h0 || instr_valid !== 1'b1) begin
            n_errors++; $display("FAIL pcwrite_hold got i=%h o=%h v=%b exp i=40000033 o=0 v=1", instr, oldpc, instr_valid);
        end
    endtask

    task automatic test_pc_update_fetch();
        pcwrite     = 1'b1;
        pc_next     = 32'h4;
        fetch_start = 1'b1;
        tick();
        pcwrite     = 1'b0;
        fetch_start = 1'b0;
        n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h4) begin
            n_errors++; $display("FAIL pcupd_req got v=%b a=%h exp v=1 a=4", bus.mem_req_valid, bus.mem_addr);
        end
        n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL pcupd_clear got %b exp 0", instr_valid); end
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h0020_c133;
        tick();
        bus.mem_rsp_valid = 1'b0;
        n_checks++; if (oldpc !== 32'h4) begin n_errors++; $display("FAIL pcupd_oldpc got %h exp 4", oldpc); end
        n_checks++; if (funct3 !== 3'd4 || opcode !== 7'h33 || func7_bit5 !== 1'b0) begin
            n_errors++; $display("FAIL pcupd_decode got f3=%h op=%h f7=%b exp f3=4 op=33 f7=0", funct3, opcode, func7_bit5);
        end
    endtask

    task automatic test_bus_error();
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        bus.mem_req_ready = 1'b1;
        // response during REQ must be ignored
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_err   = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        n_checks++; if (busy !== 1'b1 || fetch_fault !== 1'b0) begin
            n_errors++; $display("FAIL buserr_req_ignore got busy=%b ff=%b exp busy=1 ff=0", busy, fetch_fault);
        end
        bus.mem_rdata = 32'hdead_beef;
        tick();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_err   = 1'b0;
        n_checks++; if (fetch_fault !== 1'b1 || instr_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++; $display("FAIL buserr_flags got ff=%b iv=%b busy=%b exp 1 0 0", fetch_fault, instr_valid, busy);
        end
        n_checks++; if (instr !== 32'h0020_c133) begin n_errors++; $display("FAIL buserr_instr got %h exp %h", instr, 32'h0020_c133); end
        // FAULT ignores control inputs
        fetch_start = 1'b1;
        pcwrite     = 1'b1;
        pc_next     = 32'h80;
        tick();
        tick();
        fetch_start = 1'b0;
        pcwrite     = 1'b0;
        n_checks++; if (fetch_fault !== 1'b1 || bus.mem_req_valid !== 1'b0 || pc !== 32'h4) begin
            n_errors++; $display("FAIL buserr_sticky got ff=%b rv=%b pc=%h exp 1 0 4", fetch_fault, bus.mem_req_valid, pc);
        end
        reset = 1'b0;
        #1;
        n_checks++; if (fetch_fault !== 1'b0 || pc !== 32'h0) begin
            n_errors++; $display("FAIL buserr_reset got ff=%b pc=%h exp 0 0", fetch_fault, pc);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_misaligned();
        pcwrite = 1'b1;
        pc_next = 32'h6;
        tick();
        pcwrite = 1'b0;
        n_checks++; if (pc !== 32'h6) begin n_errors++; $display("FAIL mis_pc got %h exp 6", pc); end
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (fetch_fault !== 1'b1 || bus.mem_req_valid !== 1'b0 || instr_valid !== 1'b0 || busy !== 1'b0) begin
                n_errors++; $display("FAIL mis_fault c%0d got ff=%b rv=%b iv=%b busy=%b exp 1 0 0 0",
                                     i, fetch_fault, bus.mem_req_valid, instr_valid, busy);
            end
            tick();
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_fetch();
        // reset during REQ drops the request without a clock edge
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (bus.mem_req_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++; $display("FAIL rst_req got rv=%b busy=%b exp 0 0", bus.mem_req_valid, busy);
        end
        tick();
        reset = 1'b1;
        tick();
        // reset during WAIT, late response afterwards
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL rst_wait_entry got busy=%b exp 1", busy); end
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
            n_errors++; $display("FAIL rst_wait_drop got busy=%b rv=%b exp 0 0", busy, bus.mem_req_valid);
        end
        tick();
        reset = 1'b1;
        tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h1234_5678;
        tick();
        bus.mem_rsp_valid = 1'b0;
        tick();
        n_checks++; if (instr !== 32'h13 || instr_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++; $display("FAIL rst_late_rsp got i=%h iv=%b busy=%b exp 00000013 0 0", instr, instr_valid, busy);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_pc_update_fetch();
        test_bus_error();
        test_misaligned();
        test_reset_mid_fetch();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Upstream fetch stage of the multicycle RV32I core: owns the PC, OldPC and instruction registers and fetches instructions from a variable-latency memory over a valid/ready request and valid response handshake. It decodes the `opcode`, `funct3` and `func7_bit5` fields that drive the control unit. The control unit triggers each fetch and commits PC updates through this block.

## Interface
- `XLEN`, 32, datapath width
- `RESET_PC`, 32'h0000_0000, PC value after reset
- `NOP_INSTR`, 32'h0000_0013, instruction register value after reset (`addi x0,x0,0`)

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `fetch_start`  in  1  single-cycle request from the control unit to fetch the instruction at `pc`
- `pcwrite`  in  1  commit `pc_next` into PC
- `pc_next`  in  XLEN  new PC value (ALU/result bus)
- `mem_req_valid`  out  1  memory read request valid
- `mem_req_ready`  in  1  memory accepts the request
- `mem_addr`  out  XLEN  request address; equals `pc` while `mem_req_valid` is high
- `mem_rsp_valid`  in  1  read data valid
- `mem_rdata`  in  32  read data
- `mem_rsp_err`  in  1  bus error, qualified by `mem_rsp_valid`
- `pc`  out  XLEN  current PC
- `oldpc`  out  XLEN  PC of the instruction currently held in `instr`
- `instr`  out  32  instruction register
- `opcode`  out  7  `instr[6:0]`
- `funct3`  out  3  `instr[14:12]`
- `func7_bit5`  out  1  `instr[30]`
- `instr_valid`  out  1  `instr` holds a freshly fetched instruction
- `busy`  out  1  fetch in progress (state REQ or WAIT)
- `fetch_fault`  out  1  sticky fault flag

## Operation
- States: IDLE, REQ, WAIT, FAULT.
- Reset (async, `reset`=0), all outputs reach these values:
  - state IDLE, `pc`=`RESET_PC`, `oldpc`=0, `instr`=`NOP_INSTR`.
  - `instr_valid`, `mem_req_valid`, `busy` and `fetch_fault` all 0.
- IDLE:
  - `pcwrite`=1 loads `pc <= pc_next`.
  - `fetch_start`=1 clears `instr_valid`. The next state is REQ, or FAULT if the PC used for the fetch has bits [1:0] ≠ 0.
  - If `fetch_start` and `pcwrite` are both high, the fetch uses `pc_next`: PC is written first, and the alignment check applies to `pc_next`.
- REQ:
  - `mem_req_valid`=1 and `mem_addr`=`pc`, both held stable until `mem_req_ready`.
  - When `mem_req_ready`=1, the next state is WAIT.
  - `mem_rsp_valid` is ignored in this state.
- WAIT:
  - `mem_req_valid`=0.
  - On `mem_rsp_valid`=1 with `mem_rsp_err`=0: `instr <= mem_rdata`, `oldpc <= pc`, `instr_valid <= 1`, next state IDLE.
  - On `mem_rsp_valid`=1 with `mem_rsp_err`=1: `instr` is unchanged, next state FAULT.
  - There is no timeout; WAIT holds indefinitely.
- FAULT:
  - `fetch_fault`=1 and `instr_valid`=0.
  - All inputs are ignored; only `reset` exits.
- `pcwrite` and `fetch_start` are ignored in REQ, WAIT and FAULT. PC is never modified while a fetch is outstanding.
- `instr_valid` stays high until the next accepted `fetch_start` or reset. `instr` and `oldpc` hold their values across later `pcwrite`s, so the control unit can compute PC+4 and branch targets from `oldpc`.
- `opcode`, `funct3` and `func7_bit5` are combinational slices of the `instr` register.
- `busy` = (state==REQ) | (state==WAIT).

## Timing
- Minimum fetch latency is 3 cycles from `fetch_start`:
  - cycle 0: `fetch_start`
  - cycle 1: REQ with `mem_req_ready`=1
  - cycle 2: WAIT with `mem_rsp_valid`=1
  - cycle 3: `instr_valid`=1 and new `instr` visible
- Each cycle of `mem_req_ready`=0 adds one cycle; each cycle of response delay adds one cycle.
- A `pcwrite` in cycle N makes the new `pc` visible in cycle N+1.
- Reset asserted mid-REQ or mid-WAIT drops `mem_req_valid` immediately (asynchronously). A late response arriving after reset is ignored, because the block is then in IDLE.

## Test plan
- Basic fetch: after reset, pulse `fetch_start`; memory ready and responds immediately with 32'h00500093 → `mem_addr`=0 in cycle 1, `instr_valid`=1 in cycle 3, `opcode`=7'h13, `funct3`=0, `oldpc`=0.
- Backpressure and slow response: `mem_req_ready` low for 3 cycles, then response 2 cycles after acceptance → `mem_addr` stable throughout REQ; `instr_valid` at cycle 7; `fetch_start` and `pcwrite` pulses during `busy` leave `pc` unchanged.
- PC update with simultaneous fetch: in IDLE, `pcwrite`=1 with `pc_next`=32'h4 and `fetch_start`=1 in the same cycle → request to address 4, `oldpc`=4 after response.
- Misaligned fetch: `pcwrite` with `pc_next`=32'h6, then `fetch_start` → no request issued, `fetch_fault`=1 sticky, `instr_valid`=0.
- Bus error: response with `mem_rsp_err`=1 → `fetch_fault`=1, `instr` retains its previous value; reset clears the fault and restores `pc`=`RESET_PC`.
- Reset mid-WAIT: assert `reset`=0 while waiting, then deliver `mem_rsp_valid` after reset is released → `mem_req_valid` drops immediately, `instr`=`NOP_INSTR`, `instr_valid` stays 0.
